receiver_i2c: RTL and testbench

I2C target (slave) for the transmitter_I2C master, the other end of the same link. It detects START/STOP, matches a 7-bit address, and ACKs address and data bytes. Write transfers capture two data bytes into a 16-bit word. Read transfers serialize a 16-bit word back to the master.

---
 rtl/receiver_i2c.sv | 206 ++++++++++++++++++++
 tb/tb_receiver_i2c.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/receiver_i2c.sv
// I2C target: START/STOP detection, 7-bit address match, ACKed two-byte write
// capture into WR_DATA and two-byte read return of RD_DATA.
module receiver_i2c #(
    parameter int unsigned ADDR_W     = 7,
    parameter int unsigned DATA_BYTES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    SCL,
    input  logic                    SDA_OUT,
    input  logic                    SDA_OE,
    input  logic [ADDR_W-1:0]       I2C_ADDR,
    input  logic [8*DATA_BYTES-1:0] RD_DATA,
    output logic                    SDA_IN,
    output logic                    SDA_IN_ACK,
    output logic [8*DATA_BYTES-1:0] WR_DATA,
    output logic                    WR_VALID,
    output logic                    RD_DONE,
    output logic                    BUSY
);

    localparam int unsigned DATA_W   = 8 * DATA_BYTES;
    localparam int unsigned IDX_W    = $clog2(DATA_BYTES + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BYTES - 1);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WR_BYTE,
        WR_ACK,
        RD_BYTE,
        RD_MACK,
        IGNORE
    } state_t;

    state_t            state;
    logic              scl_q;
    logic              sda_q;
    logic [3:0]        bit_cnt;
    logic [IDX_W-1:0]  byte_idx;
    logic [DATA_W-2:0] rx_sh;
    logic [DATA_W-2:0] tx_sh;
    logic              rnw;

    // Bus SDA as seen on the wire (pull-up when the master releases it)
    logic sda_c;
    logic scl_rise_c;
    logic scl_fall_c;
    logic start_c;
    logic stop_c;

    assign sda_c      = SDA_OE ? SDA_OUT : 1'b1;
    assign scl_rise_c = SCL & ~scl_q;
    assign scl_fall_c = ~SCL & scl_q;
    assign start_c    = SCL & scl_q & sda_q & ~sda_c;
    assign stop_c     = SCL & scl_q & ~sda_q & sda_c;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            scl_q      <= 1'b1;
            sda_q      <= 1'b1;
            bit_cnt    <= 4'd0;
            byte_idx   <= '0;
            rx_sh      <= '0;
            tx_sh      <= '0;
            rnw        <= 1'b0;
            SDA_IN     <= 1'b1;
            SDA_IN_ACK <= 1'b0;
            WR_DATA    <= '0;
            WR_VALID   <= 1'b0;
            RD_DONE    <= 1'b0;
            BUSY       <= 1'b0;
        end else begin
            scl_q    <= SCL;
            sda_q    <= sda_c;
            WR_VALID <= 1'b0;
            RD_DONE  <= 1'b0;

            // Bus conditions win over any bit-level activity in the same cycle
            if (start_c) begin
                state      <= ADDR;
                bit_cnt    <= 4'd0;
                byte_idx   <= '0;
                rx_sh      <= '0;
                SDA_IN     <= 1'b1;
                SDA_IN_ACK <= 1'b0;
                BUSY       <= 1'b0;
            end else if (stop_c) begin
                state      <= IDLE;
                bit_cnt    <= 4'd0;
                byte_idx   <= '0;
                SDA_IN     <= 1'b1;
                SDA_IN_ACK <= 1'b0;
                BUSY       <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        SDA_IN     <= 1'b1;
                        SDA_IN_ACK <= 1'b0;
                    end

                    ADDR: begin
                        if (scl_rise_c) begin
                            rx_sh <= {rx_sh[DATA_W-3:0], sda_c};
                            if (bit_cnt == 4'd7) begin
                                bit_cnt <= 4'd0;
                                rnw     <= sda_c;
                                if (rx_sh[ADDR_W-1:0] == I2C_ADDR) begin
                                    state <= ADDR_ACK;
                                    BUSY  <= 1'b1;
                                end else begin
                                    state <= IGNORE;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end
                    end

                    // SDA_IN_ACK doubles as the "ACK already driven" marker
                    ADDR_ACK, WR_ACK: begin
                        if (scl_fall_c) begin
                            if (!SDA_IN_ACK) begin
                                SDA_IN     <= 1'b0;
                                SDA_IN_ACK <= 1'b1;
                            end else begin
                                SDA_IN     <= 1'b1;
                                SDA_IN_ACK <= 1'b0;
                                if (state == ADDR_ACK) begin
                                    if (rnw) begin
                                        tx_sh  <= RD_DATA[DATA_W-2:0];
                                        SDA_IN <= RD_DATA[DATA_W-1];
                                        state  <= RD_BYTE;
                                    end else begin
                                        state <= WR_BYTE;
                                    end
                                end else if (byte_idx == LAST_IDX) begin
                                    state <= IGNORE;
                                end else begin
                                    byte_idx <= byte_idx + IDX_W'(1);
                                    state    <= WR_BYTE;
                                end
                            end
                        end
                    end

                    WR_BYTE: begin
                        if (scl_rise_c) begin
                            rx_sh <= {rx_sh[DATA_W-3:0], sda_c};
                            if (bit_cnt == 4'd7) begin
                                bit_cnt <= 4'd0;
                                state   <= WR_ACK;
                                if (byte_idx == LAST_IDX) begin
                                    WR_DATA  <= {rx_sh, sda_c};
                                    WR_VALID <= 1'b1;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end
                    end

                    // bit_cnt counts rises; the fall after the 8th rise releases SDA
                    RD_BYTE: begin
                        if (scl_rise_c) begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall_c) begin
                            if (bit_cnt == 4'd8) begin
                                bit_cnt <= 4'd0;
                                SDA_IN  <= 1'b1;
                                state   <= RD_MACK;
                            end else begin
                                SDA_IN <= tx_sh[DATA_W-2];
                                tx_sh  <= {tx_sh[DATA_W-3:0], 1'b0};
                            end
                        end
                    end

                    RD_MACK: begin
                        if (scl_rise_c) begin
                            if (!sda_c && byte_idx != LAST_IDX) begin
                                byte_idx <= byte_idx + IDX_W'(1);
                                state    <= RD_BYTE;
                            end else begin
                                RD_DONE <= 1'b1;
                                state   <= IGNORE;
                            end
                        end
                    end

                    IGNORE: begin
                        SDA_IN     <= 1'b1;
                        SDA_IN_ACK <= 1'b0;
                    end

                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_receiver_i2c.sv
// Bench for receiver_i2c: a bit-level I2C master drives directed and random
// transactions; expectations come from a transaction-level model of the target.
module tb_receiver_i2c;

    logic        clk      = 1'b0;
    logic        rst      = 1'b0;
    logic        SCL      = 1'b1;
    logic        SDA_OUT  = 1'b1;
    logic        SDA_OE   = 1'b0;
    logic [6:0]  I2C_ADDR = 7'h5A;
    logic [15:0] RD_DATA  = 16'h0000;
    logic        SDA_IN;
    logic        SDA_IN_ACK;
    logic [15:0] WR_DATA;
    logic        WR_VALID;
    logic        RD_DONE;
    logic        BUSY;

    int          checks   = 0;
    int          errors   = 0;
    int          wv_cnt   = 0;
    int          rd_cnt   = 0;
    int          exp_wv   = 0;
    int          exp_rd   = 0;
    logic [15:0] exp_wr   = 16'h0000;
    logic        bus_idle = 1'b1;

    receiver_i2c dut (
        .clk        (clk),
        .rst        (rst),
        .SCL        (SCL),
        .SDA_OUT    (SDA_OUT),
        .SDA_OE     (SDA_OE),
        .I2C_ADDR   (I2C_ADDR),
        .RD_DATA    (RD_DATA),
        .SDA_IN     (SDA_IN),
        .SDA_IN_ACK (SDA_IN_ACK),
        .WR_DATA    (WR_DATA),
        .WR_VALID   (WR_VALID),
        .RD_DONE    (RD_DONE),
        .BUSY       (BUSY)
    );

    always #5 clk = ~clk;

    // Pulse counters: a pulse wider than one clk counts more than once
    always @(negedge clk) begin
        if (WR_VALID === 1'b1) wv_cnt++;
        if (RD_DONE === 1'b1) rd_cnt++;
    end

    initial begin
        #600000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "bench timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic hold();
        repeat ($urandom_range(4, 2)) @(negedge clk);
    endtask

    // One SCL period; samples {SDA_IN, SDA_IN_ACK, BUSY} at start and end of the high phase
    task automatic bit_cycle(input logic oe, input logic val,
                             output logic [2:0] f, output logic [2:0] l);
        int n;
        SDA_OE  = oe;
        SDA_OUT = val;
        hold();
        SCL = 1'b1;
        n = int'($urandom_range(4, 2));
        @(negedge clk);
        f = {SDA_IN, SDA_IN_ACK, BUSY};
        repeat (n - 1) @(negedge clk);
        l = {SDA_IN, SDA_IN_ACK, BUSY};
        SCL = 1'b0;
    endtask

    task automatic do_start();
        if (bus_idle) begin
            SDA_OE  = 1'b1;
            SDA_OUT = 1'b0;
            hold();
            SCL = 1'b0;
            hold();
        end else begin
            SDA_OE = 1'b0;
            hold();
            SCL = 1'b1;
            hold();
            SDA_OE  = 1'b1;
            SDA_OUT = 1'b0;
            hold();
            SCL = 1'b0;
            hold();
        end
        bus_idle = 1'b0;
    endtask

    task automatic do_stop();
        SDA_OE  = 1'b1;
        SDA_OUT = 1'b0;
        hold();
        SCL = 1'b1;
        hold();
        SDA_OE = 1'b0;
        hold();
        hold();
        bus_idle = 1'b1;
        check("stop_idle", 32'({BUSY, SDA_IN, SDA_IN_ACK}), 32'(3'b010));
    endtask

    // Master sends a byte; the target must keep SDA released and no ACK flag
    task automatic send_byte(input logic [7:0] b);
        logic [2:0] f;
        logic [2:0] l;
        logic       rel_ok;
        rel_ok = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bit_cycle(1'b1, b[7-i], f, l);
            if (f[2:1] != 2'b10 || l[2:1] != 2'b10) rel_ok = 1'b0;
        end
        check("wr_byte_rel", 32'(rel_ok), 32'(1'b1));
    endtask

    task automatic ack_slot(input logic e, input string tag, output logic busy);
        logic [2:0] f;
        logic [2:0] l;
        bit_cycle(1'b0, 1'b1, f, l);
        check(tag, 32'({f[2:1], l[2:1]}), 32'({~e, e, ~e, e}));
        busy = l[0];
    endtask

    task automatic read_byte(output logic [7:0] bf, output logic [7:0] bl);
        logic [2:0] f;
        logic [2:0] l;
        bf = 8'h00;
        bl = 8'h00;
        for (int i = 0; i < 8; i++) begin
            bit_cycle(1'b0, 1'b1, f, l);
            bf = {bf[6:0], f[2]};
            bl = {bl[6:0], l[2]};
            // RD_DATA must already be latched; scramble it mid-byte
            if (i == 0) RD_DATA = 16'($urandom);
        end
    endtask

    task automatic master_ack(input logic v);
        logic [2:0] f;
        logic [2:0] l;
        bit_cycle(1'b1, v, f, l);
        check("mack_rel", 32'({f[2:1], l[2:1]}), 32'(4'b1010));
    endtask

    // Model: target ACKs a matching address and the first two data bytes only;
    // WR_DATA is committed only once two bytes have arrived
    task automatic write_xfer(input logic [6:0] a, input int n, input logic [31:0] d,
                              input logic stop);
        logic        match;
        logic        busy;
        logic [31:0] db;
        match = (a == I2C_ADDR);
        db    = d;
        do_start();
        send_byte({a, 1'b0});
        ack_slot(match, "wr_addr_ack", busy);
        check("wr_busy", 32'(busy), 32'(match));
        for (int k = 0; k < n; k++) begin
            send_byte(db[31:24]);
            db = db << 8;
            ack_slot(match && (k < 2), "wr_data_ack", busy);
        end
        if (match && n >= 2) begin
            exp_wr = d[31:16];
            exp_wv++;
        end
        if (stop) do_stop();
        check("wr_data", 32'(WR_DATA), 32'(exp_wr));
        check("wr_valid_cnt", 32'(wv_cnt), 32'(exp_wv));
    endtask

    // Model: a matching read returns RD_DATA as seen at the address phase, MSB first;
    // byte 1 only after a master ACK; SDA stays released otherwise
    task automatic read_xfer(input logic [6:0] a, input logic ack0);
        logic        match;
        logic        busy;
        logic [15:0] w;
        logic [7:0]  bf;
        logic [7:0]  bl;
        match = (a == I2C_ADDR);
        w     = RD_DATA;
        do_start();
        send_byte({a, 1'b1});
        ack_slot(match, "rd_addr_ack", busy);
        check("rd_busy", 32'(busy), 32'(match));
        if (match) begin
            read_byte(bf, bl);
            check("rd_byte0", 32'({bf, bl}), 32'({w[15:8], w[15:8]}));
            master_ack(~ack0);
            if (ack0) begin
                read_byte(bf, bl);
                check("rd_byte1", 32'({bf, bl}), 32'({w[7:0], w[7:0]}));
                master_ack(1'b1);
            end else begin
                read_byte(bf, bl);
                check("rd_after_nack", 32'({bf, bl}), 32'(16'hFFFF));
            end
            exp_rd++;
        end else begin
            read_byte(bf, bl);
            check("rd_nomatch", 32'({bf, bl}), 32'(16'hFFFF));
        end
        do_stop();
        check("rd_done_cnt", 32'(rd_cnt), 32'(exp_rd));
    endtask

    initial begin
        logic [2:0] f;
        logic [2:0] l;
        logic [2:0] bits;
        logic       busy;

        repeat (3) @(negedge clk);
        check("reset", 32'({SDA_IN, SDA_IN_ACK, WR_DATA, WR_VALID, RD_DONE, BUSY}),
              32'({1'b1, 1'b0, 16'h0000, 3'b000}));
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Directed cases
        write_xfer(7'h5A, 2, 32'hBEEF_0000, 1'b1);
        write_xfer(7'h33, 2, 32'h1122_0000, 1'b1);
        RD_DATA = 16'hA55A;
        read_xfer(7'h5A, 1'b1);
        RD_DATA = 16'h3C96;
        read_xfer(7'h5A, 1'b0);
        write_xfer(7'h5A, 1, 32'hBE00_0000, 1'b1);
        write_xfer(7'h5A, 1, 32'hBE00_0000, 1'b0);
        write_xfer(7'h5A, 2, 32'h1234_0000, 1'b1);

        // Reset in the middle of a read, while bit 3 of byte 0 is driven
        RD_DATA = 16'hA55A;
        do_start();
        send_byte(8'hB5);
        ack_slot(1'b1, "rst_addr_ack", busy);
        bits = 3'b000;
        for (int i = 0; i < 3; i++) begin
            bit_cycle(1'b0, 1'b1, f, l);
            bits = {bits[1:0], f[2]};
        end
        check("rst_pre_bits", 32'(bits), 32'(3'b101));
        @(negedge clk);
        check("rst_pre_bit3", 32'(SDA_IN), 32'(1'b0));
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid", 32'({SDA_IN, SDA_IN_ACK, BUSY, WR_DATA}), 32'({3'b100, 16'h0000}));
        rst    = 1'b1;
        exp_wr = 16'h0000;
        do_stop();
        write_xfer(7'h5A, 2, 32'hC3A7_0000, 1'b1);

        // Random transactions
        for (int t = 0; t < 30; t++) begin
            logic [6:0] a;
            if (bus_idle && $urandom_range(3, 0) == 0) I2C_ADDR = 7'($urandom);
            a = ($urandom_range(1, 0) == 1) ? I2C_ADDR : 7'($urandom);
            if ($urandom_range(1, 0) == 1) begin
                RD_DATA = 16'($urandom);
                read_xfer(a, 1'($urandom_range(1, 0)));
            end else begin
                write_xfer(a, int'($urandom_range(3, 0)), $urandom,
                           ($urandom_range(3, 0) != 0));
            end
        end
        if (!bus_idle) do_stop();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
